// File: rtl/bomberman_pkg.sv
// Shared definitions for the game's drawing path: requester indices and the
// draw-port arbiter state encoding.
package bomberman_pkg;

    localparam int NUM_DRAW_REQ = 4;

    localparam int REQ_STAGE = 0;
    localparam int REQ_TILE  = 1;
    localparam int REQ_P1    = 2;
    localparam int REQ_P2    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DRAW_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester with req high, searching
// from ptr upward modulo 4.
module rr_picker
    import bomberman_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] pick,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_DRAW_REQ; k++) begin
            // 2-bit addition wraps, giving the modulo-4 search order
            idx = ptr + 2'(k);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Round-robin owner of the VGA adapter write port for the four drawing engines,
// with a per-burst watchdog and registered pixel outputs.
module draw_port_arbiter
    import bomberman_pkg::*;
#(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3,
    parameter int MAX_BURST = 19200
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [3:0]            plot_in,
    input  logic [3:0]            last_in,
    input  logic [4*X_W-1:0]      x_in,
    input  logic [4*Y_W-1:0]      y_in,
    input  logic [4*COLOUR_W-1:0] colour_in,
    output logic [3:0]            grant,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic [COLOUR_W-1:0]   colour,
    output logic                  plot,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t     state;
    logic [1:0]     ptr;
    logic [1:0]     owner;
    logic [CNT_W-1:0] cnt;
    logic [3:0]     pick;
    logic           pick_valid;

    rr_picker u_picker (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            grant       <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        owner <= onehot_to_idx(pick);
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Priority: normal end, then abort, then watchdog
                    if (plot_in[owner] && last_in[owner]) begin
                        x      <= x_in[owner*X_W +: X_W];
                        y      <= y_in[owner*Y_W +: Y_W];
                        colour <= colour_in[owner*COLOUR_W +: COLOUR_W];
                        plot   <= 1'b1;
                        state  <= RELEASE;
                    end else if (!req[owner]) begin
                        state <= RELEASE;
                    end else begin
                        if (plot_in[owner]) begin
                            x      <= x_in[owner*X_W +: X_W];
                            y      <= y_in[owner*Y_W +: Y_W];
                            colour <= colour_in[owner*COLOUR_W +: COLOUR_W];
                            plot   <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= RELEASE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    grant <= '0;
                    ptr   <= owner + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
